hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Pipeline control counterpart to operand forwarding: where forwarding cannot resolve a hazard, this block stalls, bubbles, flushes or freezes the 5-stage DLX pipeline.
- Covers three cases: load-use hazards (1-cycle stall plus ID/EX bubble), taken-branch IF/ID flush, and a data-memory wait-state freeze with a timeout error FSM.
- Keeps saturating stall and flush performance counters.

Parameters:
- MEM_TIMEOUT, 16, number of consecutive not-ready MEM_WAIT cycles tolerated before entering ERROR (valid range 1..255).
- CNT_W, 16, width of the stall_cnt and flush_cnt performance counters.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- IFID_rs  input  5  rs field of the instruction in ID.
- IFID_rt  input  5  rt field of the instruction in ID.
- IFID_uses_rt  input  1  1 when the ID instruction reads rt as a source (R-type, store, branch-compare).
- IDEX_rt  input  5  destination register of the load currently in EX.
- IDEX_MemRead  input  1  the EX instruction is a load.
- EXMEM_MemRead  input  1  the MEM-stage instruction reads data memory.
- EXMEM_MemWrite  input  1  the MEM-stage instruction writes data memory.
- dmem_ready  input  1  data memory has completed the current access this cycle.
- branch_taken  input  1  branch in ID resolved taken this cycle.
- PC_write  output  1  PC update enable.
- IFID_write  output  1  IF/ID register load enable.
- IFID_flush  output  1  zero the IF/ID register (NOP) at the next edge.
- IDEX_write  output  1  ID/EX register load enable.
- IDEX_bubble  output  1  load zeroed control bits into ID/EX.
- EXMEM_write  output  1  EX/MEM register load enable.
- MEMWB_bubble  output  1  load zeroed control bits into MEM/WB.
- mem_error  output  1  sticky memory-timeout error flag.
- stall_cnt  output  CNT_W  count of cycles with PC_write=0.
- flush_cnt  output  CNT_W  count of cycles with IFID_flush=1.

Behaviour:
- Internal signals:
  - mem_req = EXMEM_MemRead | EXMEM_MemWrite.
  - freeze = (mem_req & ~dmem_ready) | (state==ERROR).
  - load_use = IDEX_MemRead & (IDEX_rt!=0) & ((IDEX_rt==IFID_rs) | (IFID_uses_rt & IDEX_rt==IFID_rt)).
- All control outputs are combinational from state and inputs, valid in the same cycle. Priority order: reset > freeze > load_use > branch_taken.
- Reset (rst_n=0, asynchronous):
  - state=RUN, wait_cnt=0, mem_error=0, stall_cnt=0, flush_cnt=0.
  - Control outputs forced: all *_write=0, IDEX_bubble=1, MEMWB_bubble=1, IFID_flush=0.
- Freeze:
  - PC_write=IFID_write=IDEX_write=EXMEM_write=0, MEMWB_bubble=1; IDEX_bubble=0, IFID_flush=0.
  - A pending load_use or branch_taken is ignored and re-evaluated after the freeze.
- Load-use (not frozen):
  - PC_write=0, IFID_write=0, IDEX_bubble=1, IDEX_write=1, EXMEM_write=1, IFID_flush=0.
  - Exactly one bubble per hazard, because the bubble clears IDEX_MemRead.
  - A simultaneous branch_taken is deferred; no flush that cycle.
- Branch (not frozen, no load_use): IFID_flush=1; all *_write=1.
- Default: all *_write=1; bubbles and flush 0.
- FSM states: RUN, MEM_WAIT, ERROR.
  - RUN -> MEM_WAIT when mem_req & ~dmem_ready; wait_cnt<=1.
  - MEM_WAIT, dmem_ready=1 -> RUN; wait_cnt<=0 (that cycle is unfrozen).
  - MEM_WAIT, ~dmem_ready, wait_cnt<MEM_TIMEOUT -> wait_cnt+1.
  - MEM_WAIT, ~dmem_ready, wait_cnt==MEM_TIMEOUT -> ERROR; mem_error<=1.
  - MEM_WAIT with mem_req dropped: treat as ready and return to RUN.
  - ERROR is absorbing until reset; the pipeline stays frozen.
  - wait_cnt is 8 bits.
- Counters, out of reset:
  - stall_cnt +1 every cycle PC_write=0.
  - flush_cnt +1 every cycle IFID_flush=1.
  - Both saturate at all-ones and never wrap.

Test Plan:
- lw r5 in EX (IDEX_MemRead=1, IDEX_rt=5), ID add reads IFID_rs=5 -> one cycle PC_write=0, IFID_write=0, IDEX_bubble=1; next cycle all writes 1; stall_cnt=1.
- IDEX_rt=0 with IFID_rs=0, and IDEX_rt=7 with IFID_rt=7 but IFID_uses_rt=0 -> no stall, all writes 1.
- branch_taken=1 and load_use=1 together -> IFID_flush=0 and stall; next cycle branch_taken=1 alone -> IFID_flush=1, flush_cnt=1.
- EXMEM_MemRead=1, dmem_ready low 3 cycles then high -> 3 frozen cycles with MEMWB_bubble=1, then RUN; stall_cnt=3; mem_error=0.
- MEM_TIMEOUT=4, dmem_ready held low -> ERROR entered on the 5th edge after the request, mem_error=1 sticky; rst_n pulse low mid-ERROR -> immediate RUN, counters 0, mem_error=0.
- CNT_W=4, 20 frozen cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
//
// Pipeline control for the 5-stage DLX pipeline. It covers the hazards that
// operand forwarding cannot resolve:
//   * load-use hazards: one-cycle stall of PC and IF/ID, plus a bubble into ID/EX
//   * taken branches: flush of the IF/ID register
//   * data-memory wait states: freezes the whole pipeline. A timeout FSM latches
//     a sticky error when memory never answers.
// Two saturating performance counters track stall cycles and flush cycles.
//
// Parameters:
//   MEM_TIMEOUT  consecutive not-ready MEM_WAIT cycles tolerated (1..255)
//   CNT_W        width of stall_cnt / flush_cnt
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   IFID_rs/rt/uses_rt   source operands of the instruction in ID
//   IDEX_rt/MemRead      destination and load flag of the instruction in EX
//   EXMEM_MemRead/Write  data-memory access of the instruction in MEM
//   dmem_ready           data memory finished the current access
//   branch_taken         branch in ID resolved taken
//   PC_write, IFID_write, IDEX_write, EXMEM_write   register load enables
//   IFID_flush           zero IF/ID at the next edge
//   IDEX_bubble, MEMWB_bubble   load zeroed control bits into ID/EX, MEM/WB
//   mem_error            sticky memory-timeout flag
//   stall_cnt, flush_cnt saturating performance counters
// ---------------------------------------------------------------------------
module hazard_stall_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IFID_rs,
    input  logic [4:0]       IFID_rt,
    input  logic             IFID_uses_rt,
    input  logic [4:0]       IDEX_rt,
    input  logic             IDEX_MemRead,
    input  logic             EXMEM_MemRead,
    input  logic             EXMEM_MemWrite,
    input  logic             dmem_ready,
    input  logic             branch_taken,
    output logic             PC_write,
    output logic             IFID_write,
    output logic             IFID_flush,
    output logic             IDEX_write,
    output logic             IDEX_bubble,
    output logic             EXMEM_write,
    output logic             MEMWB_bubble,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_next;

    logic mem_req;
    logic freeze;
    logic load_use;

    assign mem_req  = EXMEM_MemRead | EXMEM_MemWrite;
    assign freeze   = (mem_req & ~dmem_ready) | (state == ERROR);
    // r0 is hardwired to zero, so a load targeting it can never cause a hazard.
    assign load_use = IDEX_MemRead & (IDEX_rt != 5'd0) &
                      ((IDEX_rt == IFID_rs) | (IFID_uses_rt & (IDEX_rt == IFID_rt)));

    // Memory wait-state FSM. A dropped request in MEM_WAIT is treated as
    // completion so the pipeline cannot hang on a cancelled access.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            RUN: begin
                if (mem_req && !dmem_ready) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (!mem_req || dmem_ready) begin
                    state_next    = RUN;
                    wait_cnt_next = 8'd0;
                end else if (wait_cnt >= TIMEOUT_VAL) begin
                    state_next = ERROR;
                end else begin
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            mem_error <= 1'b0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_cnt_next;
            mem_error <= mem_error | (state_next == ERROR);
        end
    end

    // Control outputs, priority reset > freeze > load_use > branch_taken.
    // While reset is asserted the pipeline holds and injects bubbles so no
    // stale control bits escape when reset is released.
    always_comb begin
        PC_write     = 1'b1;
        IFID_write   = 1'b1;
        IFID_flush   = 1'b0;
        IDEX_write   = 1'b1;
        IDEX_bubble  = 1'b0;
        EXMEM_write  = 1'b1;
        MEMWB_bubble = 1'b0;
        if (!rst_n) begin
            PC_write     = 1'b0;
            IFID_write   = 1'b0;
            IDEX_write   = 1'b0;
            EXMEM_write  = 1'b0;
            IDEX_bubble  = 1'b1;
            MEMWB_bubble = 1'b1;
        end else if (freeze) begin
            PC_write     = 1'b0;
            IFID_write   = 1'b0;
            IDEX_write   = 1'b0;
            EXMEM_write  = 1'b0;
            MEMWB_bubble = 1'b1;
        end else if (load_use) begin
            // The bubble clears IDEX_MemRead, so the hazard lasts one cycle;
            // a taken branch in the same cycle is re-evaluated next cycle.
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_bubble = 1'b1;
        end else if (branch_taken) begin
            IFID_flush = 1'b1;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!PC_write && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (IFID_flush && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_unit
//
// Directed scenarios followed by randomized traffic for hazard_stall_unit,
// built with MEM_TIMEOUT=4 and CNT_W=4 so that the timeout and counter
// saturation are reachable in a few cycles. A behavioural reference model
// tracks the error flag, the length of the current memory wait and both
// counters as plain integers.
// ---------------------------------------------------------------------------
module tb_hazard_stall_unit;

    localparam int TO  = 4;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic [4:0]    IFID_rs;
    logic [4:0]    IFID_rt;
    logic          IFID_uses_rt;
    logic [4:0]    IDEX_rt;
    logic          IDEX_MemRead;
    logic          EXMEM_MemRead;
    logic          EXMEM_MemWrite;
    logic          dmem_ready;
    logic          branch_taken;
    logic          PC_write;
    logic          IFID_write;
    logic          IFID_flush;
    logic          IDEX_write;
    logic          IDEX_bubble;
    logic          EXMEM_write;
    logic          MEMWB_bubble;
    logic          mem_error;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    int compared;
    int mismatched;

    // Reference model state.
    bit m_err;
    int m_wait;
    int m_stall;
    int m_flush;
    // Expected controls: {PC_write, IFID_write, IFID_flush, IDEX_write,
    // IDEX_bubble, EXMEM_write, MEMWB_bubble}
    logic [6:0] m_ctl;

    hazard_stall_unit #(
        .MEM_TIMEOUT(TO),
        .CNT_W      (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .IFID_rs       (IFID_rs),
        .IFID_rt       (IFID_rt),
        .IFID_uses_rt  (IFID_uses_rt),
        .IDEX_rt       (IDEX_rt),
        .IDEX_MemRead  (IDEX_MemRead),
        .EXMEM_MemRead (EXMEM_MemRead),
        .EXMEM_MemWrite(EXMEM_MemWrite),
        .dmem_ready    (dmem_ready),
        .branch_taken  (branch_taken),
        .PC_write      (PC_write),
        .IFID_write    (IFID_write),
        .IFID_flush    (IFID_flush),
        .IDEX_write    (IDEX_write),
        .IDEX_bubble   (IDEX_bubble),
        .EXMEM_write   (EXMEM_write),
        .MEMWB_bubble  (MEMWB_bubble),
        .mem_error     (mem_error),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected controls follow straight from the hazard rules and priorities.
    function automatic logic [6:0] expectedCtl();
        bit frz;
        bit lu;
        frz = m_err || ((EXMEM_MemRead || EXMEM_MemWrite) && !dmem_ready);
        lu  = IDEX_MemRead && (IDEX_rt != 0) &&
              ((IDEX_rt == IFID_rs) || (IFID_uses_rt && (IDEX_rt == IFID_rt)));
        if (!rst_n)            return 7'b0000101;
        else if (frz)          return 7'b0000001;
        else if (lu)           return 7'b0001110;
        else if (branch_taken) return 7'b1111010;
        else                   return 7'b1101010;
    endfunction

    function automatic int satInc(int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic modelReset();
        m_err   = 1'b0;
        m_wait  = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    // Advance the model across one rising edge using the pre-edge controls.
    task automatic modelEdge(input logic [6:0] ctl);
        if (rst_n) begin
            if (!ctl[6]) m_stall = satInc(m_stall);
            if (ctl[4])  m_flush = satInc(m_flush);
            if (!m_err) begin
                if ((EXMEM_MemRead || EXMEM_MemWrite) && !dmem_ready) begin
                    if (m_wait == TO) m_err = 1'b1;
                    else              m_wait = m_wait + 1;
                end else begin
                    m_wait = 0;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [6:0] got;
        m_ctl = expectedCtl();
        got   = {PC_write, IFID_write, IFID_flush, IDEX_write,
                 IDEX_bubble, EXMEM_write, MEMWB_bubble};
        compared++;
        assert (got === m_ctl) else begin
            mismatched++;
            $error("[TB] FAIL %s ctl observed=%b expected=%b", tag, got, m_ctl);
        end
        compared++;
        assert (mem_error === m_err) else begin
            mismatched++;
            $error("[TB] FAIL %s mem_error observed=%b expected=%b", tag, mem_error, m_err);
        end
        compared++;
        assert (stall_cnt === CW'(m_stall)) else begin
            mismatched++;
            $error("[TB] FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, m_stall);
        end
        compared++;
        assert (flush_cnt === CW'(m_flush)) else begin
            mismatched++;
            $error("[TB] FAIL %s flush_cnt observed=%0d expected=%0d", tag, flush_cnt, m_flush);
        end
    endtask

    // Drive one cycle of inputs, check the settled outputs, then clock it.
    task automatic applyStimulus(input string tag,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic uses, input logic [4:0] xrt,
                                 input logic xmr, input logic mr, input logic mw,
                                 input logic rdy, input logic br);
        IFID_rs        = rs;
        IFID_rt        = rt;
        IFID_uses_rt   = uses;
        IDEX_rt        = xrt;
        IDEX_MemRead   = xmr;
        EXMEM_MemRead  = mr;
        EXMEM_MemWrite = mw;
        dmem_ready     = rdy;
        branch_taken   = br;
        #1;
        checkOutput(tag);
        @(posedge clk);
        modelEdge(m_ctl);
        #1;
    endtask

    task automatic quiet(input string tag);
        applyStimulus(tag, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Asynchronous reset pulse taken between clock edges.
    task automatic pulseReset(input string tag);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput(tag);
        @(posedge clk);
        #1;
        checkOutput(tag);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic checkConst(input string tag, input int got, input int exp);
        compared++;
        assert (got == exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        modelReset();
        rst_n          = 1'b0;
        IFID_rs        = 5'd0;
        IFID_rt        = 5'd0;
        IFID_uses_rt   = 1'b0;
        IDEX_rt        = 5'd0;
        IDEX_MemRead   = 1'b0;
        EXMEM_MemRead  = 1'b0;
        EXMEM_MemWrite = 1'b0;
        dmem_ready     = 1'b1;
        branch_taken   = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_hold");
        rst_n = 1'b1;
        #1;
        quiet("idle");

        // Load-use on rs: one stall, then the bubble has cleared the load.
        applyStimulus("lu_rs", 5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("lu_after", 5'd5, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkConst("lu_stall_cnt", int'(stall_cnt), 1);

        // Non-hazards: r0 destination, rt match without rt use.
        applyStimulus("lu_r0", 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("lu_nouse", 5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("lu_rt", 5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Branch deferred behind a load-use, then taken alone.
        applyStimulus("br_lu", 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("br_only", 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkConst("br_flush_cnt", int'(flush_cnt), 1);

        // Three wait states then ready.
        pulseReset("rst_a");
        for (int i = 0; i < 3; i++)
            applyStimulus("mw3", 5'd2, 5'd2, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus("mw3_rdy", 5'd2, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkConst("mw3_stall_cnt", int'(stall_cnt), 3);
        checkConst("mw3_err", int'(mem_error), 0);

        // Write request dropped mid-wait behaves as completion.
        applyStimulus("drop_a", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus("drop_b", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Timeout: ERROR after the fifth edge, sticky, then async reset.
        pulseReset("rst_b");
        for (int i = 0; i < 5; i++)
            applyStimulus("to_wait", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkConst("to_err_set", int'(mem_error), 1);
        for (int i = 0; i < 16; i++)
            applyStimulus("to_sticky", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkConst("sat_stall_cnt", int'(stall_cnt), SAT);
        pulseReset("rst_err");
        quiet("post_err");

        // Randomized traffic with small register numbers so hazards are frequent.
        for (int n = 0; n < 400; n++) begin
            if ((n % 60) == 59) pulseReset("rst_rand");
            applyStimulus("rand",
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom), 5'($urandom_range(0, 3)),
                          1'($urandom), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) != 0),
                          1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
